keypad_input_driver: RTL and testbench



---
 rtl/calc_io_pkg.sv | 16 +
 rtl/lowest_set_bit_encoder.sv | 22 ++
 rtl/keypad_input_driver.sv | 165 ++++++++++++++++
 tb/tb_keypad_input_driver.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/calc_io_pkg.sv
// Shared definitions for the calculator I/O blocks: keypad scan states and
// the default key-index width used by the core's key decoder.
package calc_io_pkg;

   typedef enum logic [2:0] {
      GAP        = 3'd0,
      LOAD       = 3'd1,
      SHIFT_LOW  = 3'd2,
      SHIFT_HIGH = 3'd3,
      EVAL       = 3'd4
   } kbd_state_t;

   localparam int NUM_KEYS_DEFAULT = 16;
   localparam int KEY_IDX_W        = $clog2(NUM_KEYS_DEFAULT);

endpackage

// File: rtl/lowest_set_bit_encoder.sv
// Priority encoder returning the index of the lowest set bit of vec and
// whether any bit is set at all.
module lowest_set_bit_encoder #(
   parameter int WIDTH = 16,
   parameter int IDX_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] vec,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      idx = {IDX_W{1'b0}};
      any = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         idx = vec[i] ? IDX_W'(i) : idx;
         any = any | vec[i];
      end
   end

endmodule

// File: rtl/keypad_input_driver.sv
// Scans a 74HC165-style keypad chain, debounces the frames and hands one key
// code per new press to the calculator core over a valid/ready handshake.
module keypad_input_driver
   import calc_io_pkg::*;
#(
   parameter int NUM_KEYS       = 16,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int SCAN_GAP       = 1000
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_sr_data,
   output logic                        o_sr_clk,
   output logic                        o_sr_load_n,
   output logic [$clog2(NUM_KEYS)-1:0] o_key_code,
   output logic                        o_valid,
   input  logic                        i_ready,
   output logic [NUM_KEYS-1:0]         o_keys_debounced
);

   localparam int IDX_W = $clog2(NUM_KEYS);
   localparam int GAP_W = (SCAN_GAP > 1) ? $clog2(SCAN_GAP) : 1;
   localparam int STB_W = $clog2(DEBOUNCE_SCANS + 1);

   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SCAN_GAP - 1);
   localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
   localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(NUM_KEYS - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [STB_W-1:0] STB_MAX  = STB_W'(DEBOUNCE_SCANS);
   localparam logic [STB_W-1:0] STB_ONE  = STB_W'(1);

   kbd_state_t          state_r;
   logic [GAP_W-1:0]    gap_cnt_r;
   logic [IDX_W-1:0]    bit_cnt_r;
   logic [NUM_KEYS-1:0] frame_r;
   logic [NUM_KEYS-1:0] last_frame_r;
   logic [STB_W-1:0]    stable_cnt_r;
   logic [NUM_KEYS-1:0] reported_r;

   logic [STB_W-1:0]    stable_next_s;
   logic [NUM_KEYS-1:0] new_press_s;
   logic [NUM_KEYS-1:0] press_bit_s;
   logic [NUM_KEYS-1:0] reported_next_s;
   logic [IDX_W-1:0]    press_idx_s;
   logic                press_any_s;
   logic                fire_s;

   // Debounce counter update for the frame being evaluated.
   always_comb begin
      stable_next_s = STB_ONE;
      if (frame_r == last_frame_r) begin
         if (stable_cnt_r == STB_MAX) begin
            stable_next_s = STB_MAX;
         end else begin
            stable_next_s = stable_cnt_r + STB_ONE;
         end
      end else begin
         stable_next_s = STB_ONE;
      end
   end

   // Scan FSM: gap, load pulse, 2*NUM_KEYS-1 shift phases, then evaluate.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r          <= GAP;
         gap_cnt_r        <= {GAP_W{1'b0}};
         bit_cnt_r        <= {IDX_W{1'b0}};
         frame_r          <= {NUM_KEYS{1'b0}};
         last_frame_r     <= {NUM_KEYS{1'b0}};
         stable_cnt_r     <= {STB_W{1'b0}};
         o_keys_debounced <= {NUM_KEYS{1'b0}};
         o_sr_clk         <= 1'b0;
         o_sr_load_n      <= 1'b1;
      end else begin
         case (state_r)
            GAP: begin
               o_sr_clk <= 1'b0;
               if (gap_cnt_r == GAP_LAST) begin
                  state_r     <= LOAD;
                  o_sr_load_n <= 1'b0;
               end else begin
                  gap_cnt_r   <= gap_cnt_r + GAP_ONE;
                  o_sr_load_n <= 1'b1;
               end
            end
            LOAD: begin
               o_sr_load_n <= 1'b1;
               o_sr_clk    <= 1'b0;
               bit_cnt_r   <= IDX_TOP;
               state_r     <= SHIFT_LOW;
            end
            SHIFT_LOW: begin
               // Keys pull QH low when pressed.
               frame_r[bit_cnt_r] <= ~i_sr_data;
               if (bit_cnt_r == {IDX_W{1'b0}}) begin
                  state_r <= EVAL;
               end else begin
                  o_sr_clk <= 1'b1;
                  state_r  <= SHIFT_HIGH;
               end
            end
            SHIFT_HIGH: begin
               o_sr_clk  <= 1'b0;
               bit_cnt_r <= bit_cnt_r - IDX_ONE;
               state_r   <= SHIFT_LOW;
            end
            EVAL: begin
               last_frame_r <= frame_r;
               stable_cnt_r <= stable_next_s;
               if (stable_next_s == STB_MAX) begin
                  o_keys_debounced <= frame_r;
               end else begin
                  o_keys_debounced <= o_keys_debounced;
               end
               gap_cnt_r <= {GAP_W{1'b0}};
               state_r   <= GAP;
            end
            default: begin
               state_r     <= GAP;
               gap_cnt_r   <= {GAP_W{1'b0}};
               o_sr_clk    <= 1'b0;
               o_sr_load_n <= 1'b1;
            end
         endcase
      end
   end

   lowest_set_bit_encoder #(
      .WIDTH (NUM_KEYS),
      .IDX_W (IDX_W)
   ) u_lsb_enc (
      .vec (new_press_s),
      .idx (press_idx_s),
      .any (press_any_s)
   );

   // Pick the next unreported key; a released key drops out of reported.
   always_comb begin
      new_press_s     = o_keys_debounced & ~reported_r;
      fire_s          = press_any_s & (~o_valid | i_ready);
      press_bit_s     = {{(NUM_KEYS-1){1'b0}}, 1'b1} << press_idx_s;
      reported_next_s = (reported_r & o_keys_debounced)
                      | (fire_s ? press_bit_s : {NUM_KEYS{1'b0}});
   end

   // Handshake: hold code and valid while the core stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_valid    <= 1'b0;
         o_key_code <= {IDX_W{1'b0}};
         reported_r <= {NUM_KEYS{1'b0}};
      end else begin
         reported_r <= reported_next_s;
         if (fire_s) begin
            o_key_code <= press_idx_s;
            o_valid    <= 1'b1;
         end else if (i_ready) begin
            o_valid <= 1'b0;
         end else begin
            o_valid <= o_valid;
         end
      end
   end

endmodule

// File: tb/tb_keypad_input_driver.sv
// Directed bench for keypad_input_driver with a behavioural 74HC165 chain.
module tb_keypad_input_driver;

   localparam int NK = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_sr_data;
   logic          o_sr_clk;
   logic          o_sr_load_n;
   logic [3:0]    o_key_code;
   logic          o_valid;
   logic          i_ready = 1'b1;
   logic [NK-1:0] o_keys_debounced;

   logic [NK-1:0] keys = '0;
   logic [NK-1:0] sh = '1;
   logic [3:0]    acc_q[$];
   int            total = 0;
   int            bad = 0;

   keypad_input_driver #(
      .NUM_KEYS       (NK),
      .DEBOUNCE_SCANS (4),
      .SCAN_GAP       (4)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .i_sr_data        (i_sr_data),
      .o_sr_clk         (o_sr_clk),
      .o_sr_load_n      (o_sr_load_n),
      .o_key_code       (o_key_code),
      .o_valid          (o_valid),
      .i_ready          (i_ready),
      .o_keys_debounced (o_keys_debounced)
   );

   always #5 clk = ~clk;

   // Chain model: pressed keys read as 0, key NK-1 is on QH right after load.
   always @(negedge o_sr_load_n or posedge o_sr_clk) begin
      if (!o_sr_load_n) sh <= ~keys;
      else              sh <= {sh[NK-2:0], 1'b1};
   end
   assign i_sr_data = sh[NK-1];

   // Record every accepted key code.
   always @(posedge clk) begin
      if (!rst && o_valid && i_ready) acc_q.push_back(o_key_code);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Returns the number of negedges until the next load pulse is seen.
   task automatic wait_load(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (o_sr_load_n !== 1'b0 && n < 200);
      check("load_seen", {31'd0, o_sr_load_n === 1'b0}, 32'd1);
   endtask

   task automatic settle_scans(input int k);
      int n;
      repeat (k) wait_load(n);
      repeat (40) @(negedge clk);
   endtask

   initial begin
      int n;
      int highs;
      int wide;
      int lows;
      logic prev;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_sr_clk", o_sr_clk, 0);
      check("rst_load_n", o_sr_load_n, 1);
      check("rst_valid", o_valid, 0);
      check("rst_code", o_key_code, 0);
      check("rst_deb", o_keys_debounced, 0);

      // First load SCAN_GAP cycles after release, then the shift pattern
      rst = 1'b0;
      wait_load(n);
      check("first_load_delay", n, 4);
      highs = 0; wide = 0; lows = 0; prev = 1'b0;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         if (o_sr_clk) highs++;
         if (o_sr_clk && prev) wide++;
         if (!o_sr_load_n) lows++;
         prev = o_sr_clk;
      end
      // The first bit is on QH after load, so 16 bits need 15 shift pulses.
      check("sr_clk_pulses", highs, 15);
      check("sr_clk_wide", wide, 0);
      check("load_extra", lows, 0);
      wait_load(n);
      check("scan_period_tail", n, 5);

      // Key 5 held from scan 3: debounced at the EVAL of scan 6
      keys = 16'h0020;
      repeat (3) wait_load(n);
      wait_load(n);
      check("k5_deb_before", o_keys_debounced, 16'h0000);
      repeat (33) @(negedge clk);
      check("k5_deb", o_keys_debounced, 16'h0020);
      check("k5_valid_pre", o_valid, 0);
      @(negedge clk);
      check("k5_valid", o_valid, 1);
      check("k5_code", o_key_code, 5);
      @(negedge clk);
      check("k5_valid_drop", o_valid, 0);
      settle_scans(3);
      check("k5_no_repeat", acc_q.size(), 1);
      check("k5_acc", acc_q[0], 5);

      // Release and press key 5 again
      keys = 16'h0000;
      settle_scans(4);
      check("k5_release_deb", o_keys_debounced, 16'h0000);
      keys = 16'h0020;
      settle_scans(4);
      check("k5b_deb", o_keys_debounced, 16'h0020);
      check("k5b_count", acc_q.size(), 2);
      check("k5b_acc", acc_q[1], 5);

      // Keys 3 and 9 together under backpressure
      keys = 16'h0000;
      settle_scans(4);
      i_ready = 1'b0;
      keys = 16'h0208;
      settle_scans(4);
      for (int i = 0; i < 10; i++) begin
         check("k39_hold_valid", o_valid, 1);
         check("k39_hold_code", o_key_code, 3);
         @(negedge clk);
      end
      i_ready = 1'b1;
      @(negedge clk);
      check("k39_second_valid", o_valid, 1);
      check("k39_second_code", o_key_code, 9);
      @(negedge clk);
      check("k39_done", o_valid, 0);
      check("k39_count", acc_q.size(), 4);
      check("k39_acc3", acc_q[2], 3);
      check("k39_acc9", acc_q[3], 9);

      // Key 7 bouncing every scan never debounces
      keys = 16'h0000;
      settle_scans(4);
      for (int i = 0; i < 6; i++) begin
         keys = (i % 2 == 0) ? 16'h0080 : 16'h0000;
         wait_load(n);
         check("k7_bounce_bit", o_keys_debounced[7], 0);
      end
      keys = 16'h0000;
      settle_scans(4);
      check("k7_final_deb", o_keys_debounced, 16'h0000);
      check("k7_no_event", acc_q.size(), 4);

      // Pending code dropped by reset during a shift-high phase
      i_ready = 1'b0;
      keys = 16'h0020;
      settle_scans(4);
      check("pend_valid", o_valid, 1);
      check("pend_code", o_key_code, 5);
      wait_load(n);
      repeat (2) @(negedge clk);
      check("rst1_in_high", o_sr_clk, 1);
      #1 rst = 1'b1;
      #1;
      check("rst1_sr_clk", o_sr_clk, 0);
      check("rst1_load_n", o_sr_load_n, 1);
      check("rst1_valid", o_valid, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      keys = 16'h0000;
      i_ready = 1'b1;
      wait_load(n);
      check("rst1_restart", n, 4);

      // Reset during SHIFT_HIGH of the second scan after release
      wait_load(n);
      repeat (2) @(negedge clk);
      check("rst2_in_high", o_sr_clk, 1);
      #1 rst = 1'b1;
      #1;
      check("rst2_sr_clk", o_sr_clk, 0);
      check("rst2_load_n", o_sr_load_n, 1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      wait_load(n);
      check("rst2_restart", n, 4);
      check("rst2_valid", o_valid, 0);
      check("rst2_deb", o_keys_debounced, 16'h0000);
      check("final_count", acc_q.size(), 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
